// File: rtl/instruction_fetch_unit.sv
// Purpose: byte-serial instruction fetcher that assembles little-endian words and queues them, tagged with their PC, in a prefetch FIFO.
// Latency: 3 cycles per byte (REQ, ACCEPT, DATA) plus memory busy time; a completed word is visible at the FIFO head the next cycle.
// Backpressure: fetch stalls at a word boundary while the FIFO is full; the decoder pops with instrValid & instrReady.
// Ports: clk/reset (async, active-high); memAddr/memRequest/memData/memBusy = MMU instruction port B;
//        redirect/redirectPc = flush and restart fetch; instr/instrPc/instrValid/instrReady = FIFO head to the decoder.
module instruction_fetch_unit #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int BUS_WIDTH     = 8,
    parameter int INSTR_WIDTH   = 32,
    parameter int FIFO_DEPTH    = 4,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [ADDRESS_WIDTH-1:0] memAddr,
    output logic                     memRequest,
    input  logic [BUS_WIDTH-1:0]     memData,
    input  logic                     memBusy,
    input  logic                     redirect,
    input  logic [ADDRESS_WIDTH-1:0] redirectPc,
    output logic [INSTR_WIDTH-1:0]   instr,
    output logic [ADDRESS_WIDTH-1:0] instrPc,
    output logic                     instrValid,
    input  logic                     instrReady
);
    localparam int BYTES = INSTR_WIDTH / BUS_WIDTH;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ~ADDRESS_WIDTH'(BYTES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(BYTES - 1);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W + 1)'(1);

    typedef enum logic [1:0] {REQ, ACCEPT, DATA} fetchStateT;

    fetchStateT               state;
    logic [ADDRESS_WIDTH-1:0] fetchPc;
    logic [IDX_W-1:0]         byteIdx;
    logic                     discard;
    logic [INSTR_WIDTH-1:0]   word;
    logic [INSTR_WIDTH-1:0]   wordNext;

    logic [INSTR_WIDTH-1:0]   instrMem [FIFO_DEPTH];
    logic [ADDRESS_WIDTH-1:0] pcMem [FIFO_DEPTH];
    logic [PTR_W-1:0]         rdPtr;
    logic [PTR_W-1:0]         wrPtr;
    logic [PTR_W:0]           count;

    logic fifoFull;
    logic byteDone;
    logic push;
    logic pop;

    assign fifoFull   = (count == FULL_COUNT);
    assign instrValid = (count != '0);
    assign instr      = instrValid ? instrMem[rdPtr] : '0;
    assign instrPc    = instrValid ? pcMem[rdPtr] : '0;

    // The access in flight finishes on the first non-busy cycle in DATA.
    assign byteDone = (state == DATA) && !memBusy;
    // Redirect kills both the completing word and any pop in the same cycle.
    assign push = byteDone && !discard && !redirect && (byteIdx == LAST_IDX);
    assign pop  = instrValid && instrReady && !redirect;

    // Assembly word with the incoming byte merged in, so the last byte can be pushed directly.
    always_comb begin
        wordNext = word;
        for (int b = 0; b < BYTES; b++) begin
            if (byteIdx == IDX_W'(b)) begin
                wordNext[b*BUS_WIDTH +: BUS_WIDTH] = memData;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= REQ;
            fetchPc    <= RESET_PC;
            byteIdx    <= '0;
            discard    <= 1'b0;
            word       <= '0;
            memAddr    <= RESET_PC;
            memRequest <= 1'b0;
        end else begin
            case (state)
                REQ: begin
                    // FIFO space is only checked at word start; a started word always has a slot.
                    if (!redirect && !((byteIdx == '0) && fifoFull)) begin
                        memRequest <= 1'b1;
                        memAddr    <= fetchPc + ADDRESS_WIDTH'(byteIdx);
                        state      <= ACCEPT;
                    end else begin
                        memRequest <= 1'b0;
                    end
                end
                ACCEPT: begin
                    if (memBusy) begin
                        memRequest <= 1'b0;
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (!memBusy) begin
                        state   <= REQ;
                        discard <= 1'b0;
                        if (!discard && !redirect) begin
                            word <= wordNext;
                            if (byteIdx == LAST_IDX) begin
                                fetchPc <= fetchPc + ADDRESS_WIDTH'(BYTES);
                                byteIdx <= '0;
                            end else begin
                                byteIdx <= byteIdx + IDX_W'(1);
                            end
                        end
                    end
                end
                default: state <= REQ;
            endcase

            // Redirect overrides the updates above. An access already issued cannot be
            // aborted, so its byte is marked for discard unless it completes this cycle.
            if (redirect) begin
                fetchPc <= redirectPc & ALIGN_MASK;
                byteIdx <= '0;
                if ((state != REQ) && !byteDone) begin
                    discard <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (redirect) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + COUNT_ONE;
            end else if (!push && pop) begin
                count <= count - COUNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instrMem[wrPtr] <= wordNext;
            pcMem[wrPtr]    <= fetchPc;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: instance 0 runs directed scenarios, instance 1 starts near the top of the address space.
module tb_instruction_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] memAddr [2];
    logic        memRequest [2];
    logic [7:0]  memData [2];
    logic        memBusy [2];
    logic        redirect [2];
    logic [31:0] redirectPc [2];
    logic [31:0] instr [2];
    logic [31:0] instrPc [2];
    logic        instrValid [2];
    logic        instrReady [2];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gDut
        instruction_fetch_unit #(
            .ADDRESS_WIDTH(32),
            .BUS_WIDTH(8),
            .INSTR_WIDTH(32),
            .FIFO_DEPTH(4),
            .RESET_PC((g == 0) ? 32'h0000_0000 : 32'hFFFF_FFF8)
        ) dut (
            .clk(clk),
            .reset(reset),
            .memAddr(memAddr[g]),
            .memRequest(memRequest[g]),
            .memData(memData[g]),
            .memBusy(memBusy[g]),
            .redirect(redirect[g]),
            .redirectPc(redirectPc[g]),
            .instr(instr[g]),
            .instrPc(instrPc[g]),
            .instrValid(instrValid[g]),
            .instrReady(instrReady[g])
        );
    end

    function automatic logic [31:0] resetPcOf(input int k);
        return (k == 0) ? 32'h0000_0000 : 32'hFFFF_FFF8;
    endfunction

    // Memory holds the low address byte at every address.
    function automatic logic [31:0] wordAt(input logic [31:0] pc);
        logic [31:0] p1;
        logic [31:0] p2;
        logic [31:0] p3;
        p1 = pc + 32'd1;
        p2 = pc + 32'd2;
        p3 = pc + 32'd3;
        return {p3[7:0], p2[7:0], p1[7:0], pc[7:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- memory model: busy for busyLen cycles, then data ----------------
    int          busyLen [2];
    int          busyLeft [2];
    logic        active [2];
    logic [31:0] accAddr [2];
    logic [31:0] accLog [$];

    always begin
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                active[k]  = 1'b0;
                memBusy[k] = 1'b0;
                memData[k] = 8'h00;
            end else if (!active[k]) begin
                if (memRequest[k]) begin
                    active[k]   = 1'b1;
                    accAddr[k]  = memAddr[k];
                    busyLeft[k] = busyLen[k];
                    memBusy[k]  = 1'b1;
                    if (k == 0) accLog.push_back(memAddr[k]);
                end
            end else begin
                busyLeft[k]--;
                if (busyLeft[k] <= 0) begin
                    memBusy[k] = 1'b0;
                    memData[k] = accAddr[k][7:0];
                    active[k]  = 1'b0;
                end
            end
        end
    end

    // ---------------- stream model and per-cycle compare ----------------
    logic [31:0] expPc [2];
    logic [31:0] reqExp [2];
    logic        prevReq [2];
    logic [31:0] popPc1 [$];
    logic [31:0] popInstr1 [$];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                check($sformatf("resetReq%0d", k), 32'(memRequest[k]), 32'd0);
                check($sformatf("resetValid%0d", k), 32'(instrValid[k]), 32'd0);
                expPc[k]   = resetPcOf(k);
                reqExp[k]  = resetPcOf(k);
                prevReq[k] = 1'b0;
            end else begin
                // Every new request must continue the byte stream.
                if (memRequest[k] && !prevReq[k]) begin
                    check($sformatf("reqAddr%0d", k), memAddr[k], reqExp[k]);
                    reqExp[k] = reqExp[k] + 32'd1;
                end
                prevReq[k] = memRequest[k];
                if (instrValid[k]) begin
                    check($sformatf("headPc%0d", k), instrPc[k], expPc[k]);
                    check($sformatf("headInstr%0d", k), instr[k], wordAt(expPc[k]));
                end
                if (redirect[k]) begin
                    expPc[k]  = redirectPc[k] & 32'hFFFF_FFFC;
                    reqExp[k] = redirectPc[k] & 32'hFFFF_FFFC;
                end else if (instrValid[k] && instrReady[k]) begin
                    if (k == 1) begin
                        popPc1.push_back(instrPc[k]);
                        popInstr1.push_back(instr[k]);
                    end
                    expPc[k] = expPc[k] + 32'd4;
                end
            end
        end
    end

    // ---------------- directed sequence (instance 0) ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic waitValid(input string name);
        for (int i = 0; i < 400 && !instrValid[0]; i++) tick();
        check(name, 32'(instrValid[0]), 32'd1);
    endtask

    // Wait for the memory model to accept an access whose address ends in lowMatch (-1: any).
    task automatic waitAcc(input int lowMatch, input string name);
        int n;
        logic [31:0] a;
        logic [1:0] lm;
        logic found;
        n = accLog.size();
        lm = lowMatch[1:0];
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            tick();
            if (accLog.size() != n) begin
                n = accLog.size();
                a = accLog[n-1];
                if (lowMatch < 0 || a[1:0] == lm) found = 1'b1;
            end
        end
        check(name, 32'(found), 32'd1);
    endtask

    task automatic waitCount(input int target, input string name);
        for (int i = 0; i < 400 && accLog.size() < target; i++) tick();
        repeat (30) tick();
        check(name, accLog.size(), target);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            redirect[k]   = 1'b0;
            redirectPc[k] = 32'h0;
            busyLen[k]    = 1;
        end
        instrReady[0] = 1'b0;
        instrReady[1] = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        for (int k = 0; k < 2; k++) begin
            check("rstMemReq", 32'(memRequest[k]), 32'd0);
            check("rstMemAddr", memAddr[k], resetPcOf(k));
            check("rstValid", 32'(instrValid[k]), 32'd0);
            check("rstInstr", instr[k], 32'h0);
            check("rstInstrPc", instrPc[k], 32'h0);
        end
        reset = 1'b0;

        // Fill with instrReady low: exactly four words, then fetch stalls.
        waitCount(16, "fillCount");
        check("fillStallReq", 32'(memRequest[0]), 32'd0);
        check("fillHeadValid", 32'(instrValid[0]), 32'd1);
        check("fillHeadInstr", instr[0], 32'h0302_0100);
        check("fillHeadPc", instrPc[0], 32'h0);
        check("fillAddr1", accLog[1], 32'h1);
        check("fillAddr15", accLog[15], 32'hF);

        // One pop frees one slot: exactly one more word, starting at 16.
        instrReady[0] = 1'b1;
        tick();
        instrReady[0] = 1'b0;
        check("pop1Instr", instr[0], 32'h0706_0504);
        check("pop1Pc", instrPc[0], 32'h4);
        waitCount(20, "refillCount");
        check("refillAddr", accLog[16], 32'h10);
        instrReady[0] = 1'b1;
        tick();
        instrReady[0] = 1'b0;
        check("pop2Instr", instr[0], 32'h0B0A_0908);
        check("pop2Pc", instrPc[0], 32'h8);

        // Redirect to 0x107 while byte 2 is in DATA with a long busy.
        busyLen[0] = 5;
        instrReady[0] = 1'b1;
        waitAcc(2, "byte2Accept");
        tick();
        n = accLog.size();
        redirect[0] = 1'b1;
        redirectPc[0] = 32'h0000_0107;
        tick();
        redirect[0] = 1'b0;
        check("redirFlush", 32'(instrValid[0]), 32'd0);
        waitValid("redirValid");
        check("redirPc", instrPc[0], 32'h104);
        check("redirInstr", instr[0], 32'h0706_0504);
        check("redirAddr", accLog[n], 32'h104);
        busyLen[0] = 1;

        // Redirect coinciding with a pop and a completing word.
        instrReady[0] = 1'b0;
        waitAcc(3, "byte3Accept");
        tick();
        check("popPreValid", 32'(instrValid[0]), 32'd1);
        n = accLog.size();
        redirect[0] = 1'b1;
        redirectPc[0] = 32'h0000_0200;
        instrReady[0] = 1'b1;
        tick();
        redirect[0] = 1'b0;
        instrReady[0] = 1'b0;
        check("popRedirFlush", 32'(instrValid[0]), 32'd0);
        waitValid("popRedirValid");
        check("popRedirPc", instrPc[0], 32'h200);
        check("popRedirInstr", instr[0], 32'h0302_0100);
        check("popRedirAddr", accLog[n], 32'h200);

        // Asynchronous reset while in ACCEPT.
        waitAcc(-1, "anyAccept");
        check("preResetReq", 32'(memRequest[0]), 32'd1);
        reset = 1'b1;
        #1;
        check("asyncReq", 32'(memRequest[0]), 32'd0);
        check("asyncValid", 32'(instrValid[0]), 32'd0);
        check("asyncAddr", memAddr[0], 32'h0);
        tick();
        tick();
        reset = 1'b0;
        n = accLog.size();
        waitAcc(-1, "restartAccept");
        check("restartAddr", accLog[n], 32'h0);
        waitValid("restartValid");
        check("restartPc", instrPc[0], 32'h0);
        check("restartInstr", instr[0], 32'h0302_0100);

        // Instance 1 wraps past the top of the address space.
        check("wrapPops", 32'(popPc1.size() >= 3), 32'd1);
        if (popPc1.size() >= 3) begin
            check("wrapPc0", popPc1[0], 32'hFFFF_FFF8);
            check("wrapPc1", popPc1[1], 32'hFFFF_FFFC);
            check("wrapPc2", popPc1[2], 32'h0000_0000);
            check("wrapInstr0", popInstr1[0], 32'hFBFA_F9F8);
            check("wrapInstr1", popInstr1[1], 32'hFFFE_FDFC);
            check("wrapInstr2", popInstr1[2], 32'h0302_0100);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
